bcd_stopwatch_ctrl: RTL



---
 rtl/bcd_stopwatch_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_stopwatch_ctrl: start/stop/clear/lap sequencer for a BCD digit bank  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_stopwatch_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  lap,
   input  logic [4*DIGITS-1:0]   target,
   input  logic [4*DIGITS-1:0]   digits_q,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  digit_rst,
   output logic                  running,
   output logic                  paused,
   output logic                  done,
   output logic                  wrapped,
   output logic                  lap_valid,
   output logic [4*DIGITS-1:0]   lap_value
);

   localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_pw-1:0] c_last = c_pw'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [c_pw-1:0]    r_presc;
   logic               r_digit_rst;
   logic               r_wrapped;
   logic               r_lap_valid;
   logic [4*DIGITS-1:0] r_lap_value;
   logic               w_match;
   logic               w_tick;
   logic [DIGITS:0]    w_nines;
   logic [DIGITS-1:0]  w_nib_ok;

   // w_nines[i] is high when every digit below i holds 9 (the carry chain)
   assign w_nines[0] = 1'b1;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         assign w_nib_ok[i]   = (target[4*i +: 4] <= 4'd9);
         assign w_nines[i+1]  = w_nines[i] & (digits_q[4*i +: 4] == 4'd9);
         assign digit_en[i]   = w_tick & w_nines[i];
      end
   endgenerate

   assign w_match = (r_state == RUN) && (target != '0) && (&w_nib_ok) && (digits_q == target);
   assign w_tick  = (r_state == RUN) && (r_presc == c_last) && !w_match && !clear && !stop;

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // stop outranks start, so a simultaneous start+stop never resumes
   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start && !stop) w_next = RUN;
            RUN:     if (stop) w_next = PAUSE;
                     else if (w_match) w_next = DONE;
            PAUSE:   if (start && !stop) w_next = RUN;
            DONE:    w_next = DONE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Prescaler only advances while staying in RUN, so pausing preserves phase
   always_ff @(posedge clk) begin
      if (reset || clear)
         r_presc <= '0;
      else if (r_state == IDLE)
         r_presc <= '0;
      else if (w_tick)
         r_presc <= '0;
      else if (r_state == RUN && w_next == RUN)
         r_presc <= r_presc + c_pw'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_digit_rst <= 1'b1;
         r_wrapped   <= 1'b0;
         r_lap_valid <= 1'b0;
         r_lap_value <= '0;
      end else begin
         r_digit_rst <= clear;
         if (clear)
            r_wrapped <= 1'b0;
         else if (w_tick && w_nines[DIGITS])
            r_wrapped <= 1'b1;
         r_lap_valid <= lap && (r_state != IDLE);
         if (lap && (r_state != IDLE))
            r_lap_value <= digits_q;
      end
   end

   assign digit_rst = r_digit_rst;
   assign wrapped   = r_wrapped;
   assign lap_valid = r_lap_valid;
   assign lap_value = r_lap_value;
   assign running   = (r_state == RUN);
   assign paused    = (r_state == PAUSE);
   assign done      = (r_state == DONE);

endmodule
`default_nettype wire
